// File: rtl/cr_clic_arb_ctrl.sv
// CLIC arbiter: scans pending/enabled sources GRP_NUM at a time, keeps the
// highest-priority (lowest index on tie) winner and presents it until ack/withdraw.
module cr_clic_arb_ctrl #(
   parameter int INT_NUM   = 64,
   parameter int PRIO_BITS = 4,
   parameter int GRP_NUM   = 8
) (
   input  logic                           clic_clk,
   input  logic                           cpurst_b,
   input  logic [INT_NUM-1:0]             int_pend,
   input  logic [INT_NUM-1:0]             int_en,
   input  logic [INT_NUM*PRIO_BITS-1:0]   int_prio,
   input  logic [PRIO_BITS-1:0]           int_thresh,
   input  logic                           core_ack,
   output logic                           arb_vld,
   output logic [$clog2(INT_NUM)-1:0]     arb_id,
   output logic [PRIO_BITS-1:0]           arb_prio,
   output logic [INT_NUM-1:0]             arb_sel_onehot
);

   localparam int ID_W    = $clog2(INT_NUM);
   localparam int GRP_CNT = INT_NUM / GRP_NUM;
   localparam int CNT_W   = (GRP_CNT > 1) ? $clog2(GRP_CNT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       grp_cnt, grp_nxt;
   logic                   best_found, found_nxt;
   logic [ID_W-1:0]        best_id, bid_nxt;
   logic [PRIO_BITS-1:0]   best_prio, bprio_nxt;
   logic                   vld_nxt;
   logic [ID_W-1:0]        id_nxt;
   logic [PRIO_BITS-1:0]   prio_nxt;
   logic [INT_NUM-1:0]     sel_nxt;

   logic [INT_NUM-1:0]             act;
   int unsigned                    grp_base;
   logic [GRP_NUM-1:0]             grp_act;
   logic [GRP_NUM*PRIO_BITS-1:0]   grp_prio;
   logic                           cand_found;
   logic [ID_W-1:0]                cand_id;
   logic [PRIO_BITS-1:0]           cand_prio;
   logic                           m_found;
   logic [ID_W-1:0]                m_id;
   logic [PRIO_BITS-1:0]           m_prio;

   assign act = int_pend & int_en;

   // Group candidate: ascending scan with strict '>' keeps the lowest index on ties.
   always_comb begin
      grp_base   = 32'(grp_cnt) * GRP_NUM;
      grp_act    = GRP_NUM'(act >> grp_base);
      grp_prio   = (GRP_NUM*PRIO_BITS)'(int_prio >> (grp_base * PRIO_BITS));
      cand_found = 1'b0;
      cand_id    = '0;
      cand_prio  = '0;
      for (int unsigned j = 0; j < GRP_NUM; j++) begin
         if (grp_act[j] && (!cand_found || (grp_prio[j*PRIO_BITS +: PRIO_BITS] > cand_prio))) begin
            cand_found = 1'b1;
            cand_id    = ID_W'(grp_base + j);
            cand_prio  = grp_prio[j*PRIO_BITS +: PRIO_BITS];
         end
      end
   end

   always_comb begin
      m_found = best_found;
      m_id    = best_id;
      m_prio  = best_prio;
      if (cand_found && (!best_found || (cand_prio > best_prio))) begin
         m_found = 1'b1;
         m_id    = cand_id;
         m_prio  = cand_prio;
      end
   end

   always_comb begin
      state_nxt = state;
      grp_nxt   = grp_cnt;
      found_nxt = best_found;
      bid_nxt   = best_id;
      bprio_nxt = best_prio;
      vld_nxt   = arb_vld;
      id_nxt    = arb_id;
      prio_nxt  = arb_prio;
      sel_nxt   = arb_sel_onehot;
      case (state)
         IDLE: begin
            if (|act) begin
               state_nxt = SCAN;
               grp_nxt   = '0;
               found_nxt = 1'b0;
            end
         end
         SCAN: begin
            found_nxt = m_found;
            bid_nxt   = m_id;
            bprio_nxt = m_prio;
            grp_nxt   = grp_cnt + 1'b1;
            if (grp_cnt == CNT_W'(GRP_CNT-1)) begin
               grp_nxt = '0;
               if (m_found && (m_prio > int_thresh)) begin
                  state_nxt = DONE;
                  vld_nxt   = 1'b1;
                  id_nxt    = m_id;
                  prio_nxt  = m_prio;
                  sel_nxt   = INT_NUM'(1) << m_id;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DONE: begin
            if (core_ack || !act[arb_id]) begin
               state_nxt = IDLE;
               vld_nxt   = 1'b0;
               id_nxt    = '0;
               prio_nxt  = '0;
               sel_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
            id_nxt    = '0;
            prio_nxt  = '0;
            sel_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clic_clk) begin
      if (!cpurst_b) begin
         state          <= IDLE;
         grp_cnt        <= '0;
         best_found     <= 1'b0;
         best_id        <= '0;
         best_prio      <= '0;
         arb_vld        <= 1'b0;
         arb_id         <= '0;
         arb_prio       <= '0;
         arb_sel_onehot <= '0;
      end else begin
         state          <= state_nxt;
         grp_cnt        <= grp_nxt;
         best_found     <= found_nxt;
         best_id        <= bid_nxt;
         best_prio      <= bprio_nxt;
         arb_vld        <= vld_nxt;
         arb_id         <= id_nxt;
         arb_prio       <= prio_nxt;
         arb_sel_onehot <= sel_nxt;
      end
   end

endmodule

// File: tb/tb_cr_clic_arb_ctrl.sv
// Directed bench for cr_clic_arb_ctrl at default parameters: latency, tie order,
// threshold, ack/withdraw, no preemption and mid-scan reset.
module tb_cr_clic_arb_ctrl;

   logic          clic_clk;
   logic          cpurst_b;
   logic [63:0]   int_pend;
   logic [63:0]   int_en;
   logic [255:0]  int_prio;
   logic [3:0]    int_thresh;
   logic          core_ack;
   logic          arb_vld;
   logic [5:0]    arb_id;
   logic [3:0]    arb_prio;
   logic [63:0]   arb_sel_onehot;

   int errors = 0;
   int checks = 0;

   cr_clic_arb_ctrl #(.INT_NUM(64), .PRIO_BITS(4), .GRP_NUM(8)) dut (
      .clic_clk       (clic_clk),
      .cpurst_b       (cpurst_b),
      .int_pend       (int_pend),
      .int_en         (int_en),
      .int_prio       (int_prio),
      .int_thresh     (int_thresh),
      .core_ack       (core_ack),
      .arb_vld        (arb_vld),
      .arb_id         (arb_id),
      .arb_prio       (arb_prio),
      .arb_sel_onehot (arb_sel_onehot)
   );

   initial clic_clk = 1'b0;
   always #5 clic_clk = ~clic_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clic_clk);
      #1;
   endtask

   initial begin
      logic seen;
      logic got;

      cpurst_b   = 1'b0;
      int_pend   = '0;
      int_en     = '0;
      int_prio   = '0;
      int_thresh = '0;
      core_ack   = 1'b0;
      step(3);
      check("rst_vld",  arb_vld, 0);
      check("rst_id",   arb_id, 0);
      check("rst_prio", arb_prio, 0);
      check("rst_sel",  arb_sel_onehot, 0);
      cpurst_b = 1'b1;
      step(2);

      // Single source 5, prio 3: presented exactly 9 edges after first pending cycle
      int_pend[5] = 1'b1;
      int_en[5]   = 1'b1;
      int_prio[5*4 +: 4] = 4'd3;
      step(8);
      check("single_vld_early", arb_vld, 0);
      step(1);
      check("single_vld",  arb_vld, 1);
      check("single_id",   arb_id, 5);
      check("single_prio", arb_prio, 3);
      check("single_sel",  arb_sel_onehot, 64'h20);
      step(2);
      check("single_hold_id", arb_id, 5);
      // Ack together with withdrawal counts as an ack
      core_ack    = 1'b1;
      int_pend[5] = 1'b0;
      step(1);
      check("ack_vld", arb_vld, 0);
      check("ack_sel", arb_sel_onehot, 0);
      core_ack = 1'b0;
      int_en   = '0;
      int_prio = '0;
      step(3);

      // Tie: 10 and 40 at prio 7, 63 at prio 6
      int_en[10] = 1'b1; int_en[40] = 1'b1; int_en[63] = 1'b1;
      int_prio[10*4 +: 4] = 4'd7;
      int_prio[40*4 +: 4] = 4'd7;
      int_prio[63*4 +: 4] = 4'd6;
      int_pend[10] = 1'b1; int_pend[40] = 1'b1; int_pend[63] = 1'b1;
      step(9);
      check("tie_vld",  arb_vld, 1);
      check("tie_id",   arb_id, 10);
      check("tie_prio", arb_prio, 7);
      check("tie_sel",  arb_sel_onehot, 64'h400);
      // Withdraw winner without ack
      int_pend[10] = 1'b0;
      step(1);
      check("withdraw_vld", arb_vld, 0);
      step(8);
      check("rescan_vld_early", arb_vld, 0);
      step(1);
      check("rescan_vld", arb_vld, 1);
      check("rescan_id",  arb_id, 40);
      // A higher-priority arrival must not preempt DONE
      int_prio[63*4 +: 4] = 4'd15;
      step(3);
      check("nopreempt_vld",  arb_vld, 1);
      check("nopreempt_id",   arb_id, 40);
      check("nopreempt_prio", arb_prio, 7);
      core_ack     = 1'b1;
      int_pend[40] = 1'b0;
      step(1);
      core_ack = 1'b0;
      check("ack2_vld", arb_vld, 0);
      // Source 63 is now taken by the next scan
      step(9);
      check("after_id",   arb_id, 63);
      check("after_prio", arb_prio, 15);
      core_ack = 1'b1;
      int_pend = '0;
      step(1);
      core_ack = 1'b0;
      int_en   = '0;
      int_prio = '0;
      step(2);

      // Threshold equal to priority: never presented
      int_en[2]   = 1'b1;
      int_prio[2*4 +: 4] = 4'd4;
      int_thresh  = 4'd4;
      int_pend[2] = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         step(1);
         if (arb_vld) seen = 1'b1;
      end
      check("thresh_eq_novld", seen, 0);
      int_thresh = 4'd3;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (arb_vld) begin
            got = 1'b1;
            break;
         end
      end
      check("thresh_lt_vld",  got, 1);
      check("thresh_lt_id",   arb_id, 2);
      check("thresh_lt_prio", arb_prio, 4);
      core_ack    = 1'b1;
      int_pend[2] = 1'b0;
      step(1);
      core_ack = 1'b0;
      check("thresh_ack_vld", arb_vld, 0);
      int_en     = '0;
      int_prio   = '0;
      int_thresh = '0;
      step(2);

      // Reset in scan cycle 4, then rescan; prio 9 vs thresh 2 checks unsigned compare
      int_en[20] = 1'b1;
      int_prio[20*4 +: 4] = 4'd9;
      int_thresh   = 4'd2;
      int_pend[20] = 1'b1;
      step(4);
      cpurst_b = 1'b0;
      step(1);
      check("midrst_vld",  arb_vld, 0);
      check("midrst_id",   arb_id, 0);
      check("midrst_prio", arb_prio, 0);
      check("midrst_sel",  arb_sel_onehot, 0);
      cpurst_b = 1'b1;
      // core_ack outside DONE must have no effect
      core_ack = 1'b1;
      step(8);
      check("postrst_vld_early", arb_vld, 0);
      core_ack = 1'b0;
      step(1);
      check("postrst_vld",  arb_vld, 1);
      check("postrst_id",   arb_id, 20);
      check("postrst_prio", arb_prio, 9);
      check("postrst_sel",  arb_sel_onehot, 64'h100000);
      int_pend[20] = 1'b0;
      step(1);
      check("postrst_withdraw_vld", arb_vld, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cr_clic_arb_ctrl.md
CR_CLIC_ARB_CTRL -- requirements
Module: cr_clic_arb_ctrl

Interface
REQ-001 SHALL have parameter INT_NUM, default 64: number of interrupt sources; an integer multiple of GRP_NUM.
REQ-002 SHALL have parameter PRIO_BITS, default 4: priority field width per source.
REQ-003 SHALL have parameter GRP_NUM, default 8: sources evaluated per scan cycle.
REQ-004 SHALL have port clic_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port cpurst_b, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port int_pend, input, INT_NUM: per-source pending flags.
REQ-007 SHALL have port int_en, input, INT_NUM: per-source enable flags.
REQ-008 SHALL have port int_prio, input, INT_NUM*PRIO_BITS: source i priority in bits [i*PRIO_BITS +: PRIO_BITS].
REQ-009 SHALL have port int_thresh, input, PRIO_BITS: core threshold; a winner must have priority strictly greater than this value.
REQ-010 SHALL have port core_ack, input, 1: the core takes the presented interrupt.
REQ-011 SHALL have port arb_vld, output, 1: a winner is presented.
REQ-012 SHALL have port arb_id, output, clog2(INT_NUM): winner index.
REQ-013 SHALL have port arb_prio, output, PRIO_BITS: winner priority.
REQ-014 SHALL have port arb_sel_onehot, output, INT_NUM: one-hot select of the winner; drives the CLIC one-hot data select; all zero when arb_vld=0.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 IDLE: if |(int_pend & int_en) is true, SHALL go to SCAN with group counter=0 and the running best cleared (best_found=0); otherwise stay in IDLE.
REQ-017 SCAN, each cycle: SHALL evaluate sources g*GRP_NUM .. g*GRP_NUM+GRP_NUM-1 with pend&en=1 and select the highest priority, lowest index on a tie.
REQ-018 SCAN merge: the group candidate SHALL replace the running best only if best_found=0 or its priority is strictly greater, so the lowest index wins among equal priorities.
REQ-019 SCAN: the group counter SHALL increment each cycle; after group INT_NUM/GRP_NUM-1, go to DONE if best_found=1 and best priority > int_thresh, else to IDLE.
REQ-020 SCAN: inputs SHALL be sampled per group in that group's cycle; input changes mid-scan SHALL NOT restart the scan.
REQ-021 Latency: with pend&en first nonzero in IDLE at cycle T, arb_vld SHALL be 1 at cycle T+INT_NUM/GRP_NUM+1 (T+9 at defaults).
REQ-022 DONE: SHALL hold arb_vld=1 and keep arb_id, arb_prio and arb_sel_onehot stable and registered.
REQ-023 DONE with core_ack=1: SHALL go to IDLE, with arb_vld=0 the next cycle.
REQ-024 DONE with core_ack=0 and pend&en of the winner 0 (withdrawal): SHALL go to IDLE, with arb_vld=0 the next cycle.
REQ-025 DONE with core_ack=1 and withdrawal in the same cycle: SHALL treat it as an ack.
REQ-026 core_ack outside DONE SHALL be ignored.
REQ-027 DONE SHALL NOT be preempted by a higher-priority arrival; that source is taken by the scan after return to IDLE.
REQ-028 arb_sel_onehot SHALL have exactly one bit set, at arb_id, whenever arb_vld=1.
REQ-029 Priorities SHALL compare as unsigned values.

Reset
REQ-030 On cpurst_b=0 at a clock edge: state=IDLE, group counter=0, best_found=0, arb_vld=0, arb_id=0, arb_prio=0, arb_sel_onehot=0.
REQ-031 Reset asserted mid-SCAN or in DONE SHALL abort with no presentation; scanning resumes at least one cycle after reset release.
REQ-032 No asynchronous reset path SHALL exist.

Verification
REQ-033 Single source: int_pend[5]=1, int_en[5]=1, prio 3, thresh 0 at cycle T -> arb_vld=1 at T+9, arb_id=5, arb_prio=3, arb_sel_onehot=1<<5.
REQ-034 Tie and priority order: sources 10 and 40 at prio 7, source 63 at prio 6 -> arb_id=10, arb_prio=7.
REQ-035 Threshold: only source 2, prio 4, thresh 4 -> arb_vld never asserts; FSM loops IDLE->SCAN->IDLE; setting thresh 3 -> next scan presents id 2.
REQ-036 Ack and withdraw: in DONE, drive core_ack=1 -> arb_vld=0 next cycle; rerun and clear int_pend of the winner -> arb_vld=0 next cycle with no ack.
REQ-037 Reset mid-scan: cpurst_b=0 in scan cycle 4 -> all outputs 0 next cycle; after release, a new scan presents the winner 9 cycles after the first IDLE cycle.
